// File: rtl/pulse_stretcher_if.sv
// Trigger/pulse bundle for pulse_stretcher.
//   i_trig     : trigger level from fabric, one request per rising edge
//   o_pulse    : stretched output pulse
//   o_busy     : high while a pulse or its trailing gap is in progress
//   o_overflow : one-cycle strobe when a trigger is dropped on a full queue
// The master modport is the trigger source; the slave modport is the stretcher.
interface pulse_stretcher_if;
  logic i_trig;
  logic o_pulse;
  logic o_busy;
  logic o_overflow;

  modport master (output i_trig, input o_pulse, o_busy, o_overflow);
  modport slave  (input i_trig, output o_pulse, o_busy, o_overflow);
endinterface

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns short trigger events into output pulses with an
// exact high time and an exact minimum low gap. Triggers arriving while a
// pulse (or its gap) is in progress are queued up to PEND_MAX deep.
// Ports:
//   clk   : single clock
//   rst_n : asynchronous active-low reset
//   bus   : pulse_stretcher_if.slave (i_trig in; o_pulse, o_busy, o_overflow out)
module pulse_stretcher #(
  parameter int HIGH_CYCLES = 500_000,
  parameter int GAP_CYCLES  = 500_000,
  parameter int PEND_MAX    = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  pulse_stretcher_if.slave  bus
);

  localparam int MAX_CYC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int PW      = $clog2(PEND_MAX + 1);

  localparam logic [CW-1:0] HIGH_LAST = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_FULL = PW'(PEND_MAX);

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [PW-1:0]   pend, pend_nxt;
  logic            r_trig_d;
  logic            rise;
  logic            drop;
  logic            pulse_q, busy_q, ovf_q;

  // r_trig_d resets high so a trigger held through reset release is not a rise
  assign rise = bus.i_trig & ~r_trig_d;

  // Next-state, counter and queue bookkeeping
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    pend_nxt  = pend;
    drop      = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (rise) state_nxt = HIGH;
      end

      HIGH: begin
        if (cnt == HIGH_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end
        if (rise) begin
          if (pend == PEND_FULL) drop = 1'b1;
          else                   pend_nxt = pend + PW'(1);
        end
      end

      GAP: begin
        if (cnt == GAP_LAST) begin
          // Final gap cycle: a pending request or a fresh rise restarts at once.
          // A rise here with pend > 0 swaps one queued entry for another.
          cnt_nxt   = '0;
          state_nxt = ((pend != '0) || rise) ? HIGH : IDLE;
          if ((pend != '0) && !rise) pend_nxt = pend - PW'(1);
        end else if (rise) begin
          if (pend == PEND_FULL) drop = 1'b1;
          else                   pend_nxt = pend + PW'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        pend_nxt  = '0;
      end
    endcase
  end

  // State, counters and registered outputs; outputs follow the next state so
  // they line up with the state register with no path from i_trig
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      pend     <= '0;
      r_trig_d <= 1'b1;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pend     <= pend_nxt;
      r_trig_d <= bus.i_trig;
      pulse_q  <= (state_nxt == HIGH);
      busy_q   <= (state_nxt != IDLE);
      ovf_q    <= drop;
    end
  end

  assign bus.o_pulse    = pulse_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher (HIGH=4, GAP=3, PEND_MAX=2).
// The reference model schedules pulse start cycles from trigger times;
// expected starts and overflow cycles go into queues that a monitor pops
// whenever the DUT shows a pulse start or an overflow strobe.
module tb_pulse_stretcher;

  localparam int H  = 4;
  localparam int G  = 3;
  localparam int PM = 2;

  logic clk;
  logic rst_n;
  pulse_stretcher_if bus ();

  pulse_stretcher #(.HIGH_CYCLES(H), .GAP_CYCLES(G), .PEND_MAX(PM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   sched[$];
  int   exp_start[$];
  int   exp_ovf[$];
  int   last_end = 0;
  logic last_trig = 1'b1;

  task automatic check_output(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s @edge %0d: got %0d, expected %0d", name, edge_cnt, actual, expected);
    end
  endtask

  // A rise sampled at edge t starts a pulse at t if nothing is running or
  // this is the last gap cycle; otherwise it waits behind the scheduled
  // pulses unless PM of them are still waiting to start.
  task automatic model_rise(input int t);
    int q;
    int start;
    if (t >= last_end) begin
      start = t;
    end else begin
      q = 0;
      foreach (sched[i]) if (sched[i] > t) q++;
      if (q >= PM) begin
        exp_ovf.push_back(t);
        return;
      end
      start = last_end;
    end
    sched.push_back(start);
    exp_start.push_back(start);
    last_end = start + H + G;
  endtask

  function automatic int model_pulse(input int e);
    foreach (sched[i]) if (e >= sched[i] && e < sched[i] + H) return 1;
    return 0;
  endfunction

  function automatic int model_busy(input int e);
    foreach (sched[i]) if (e >= sched[i] && e < sched[i] + H + G) return 1;
    return 0;
  endfunction

  task automatic model_flush();
    sched.delete();
    exp_start.delete();
    exp_ovf.delete();
    last_end = 0;
  endtask

  task automatic apply_stimulus(input logic val);
    @(negedge clk);
    bus.i_trig = val;
    if (val && !last_trig) model_rise(edge_cnt + 1);
    last_trig = val;
  endtask

  task automatic apply_pattern(input logic [15:0] pat, input int n);
    for (int i = 0; i < n; i++) apply_stimulus(pat[i]);
  endtask

  task automatic do_reset(input logic hold);
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_trig = hold;
    #1;
    check_output("reset_pulse", int'(bus.o_pulse), 0);
    check_output("reset_busy", int'(bus.o_busy), 0);
    check_output("reset_overflow", int'(bus.o_overflow), 0);
    model_flush();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_trig = 1'b1;
  endtask

  task automatic drain_check(input string name);
    for (int i = 0; i < 100 && edge_cnt <= last_end; i++) apply_stimulus(1'b0);
    check_output({name, "_drain_done"}, int'(edge_cnt > last_end), 1);
    apply_stimulus(1'b0);
    check_output({name, "_pulses_left"}, exp_start.size(), 0);
    check_output({name, "_overflows_left"}, exp_ovf.size(), 0);
  endtask

  // Monitor: compares every cycle's level against the schedule and pops the
  // scoreboard whenever the DUT starts a pulse or strobes overflow
  logic prev_pulse = 1'b0;
  int   cur_start  = 0;
  always @(posedge clk) begin
    int e;
    int s;
    #1;
    if (!rst_n) begin
      prev_pulse = 1'b0;
    end else begin
      e = edge_cnt;
      check_output("pulse_level", int'(bus.o_pulse), model_pulse(e));
      check_output("busy_level", int'(bus.o_busy), model_busy(e));
      if (bus.o_pulse && !prev_pulse) begin
        cur_start = e;
        if (exp_start.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_pulse @edge %0d: got start, expected none", e);
        end else begin
          s = exp_start.pop_front();
          check_output("pulse_start", e, s);
        end
      end
      if (!bus.o_pulse && prev_pulse) check_output("pulse_width", e - cur_start, H);
      if (bus.o_overflow) begin
        if (exp_ovf.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_overflow @edge %0d: got 1, expected 0", e);
        end else begin
          s = exp_ovf.pop_front();
          check_output("overflow_cycle", e, s);
        end
      end
      prev_pulse = bus.o_pulse;
    end
  end

  initial begin
    // Trigger held high through reset release must not fire
    rst_n = 1'b0;
    bus.i_trig = 1'b1;
    repeat (3) @(negedge clk);
    check_output("por_pulse", int'(bus.o_pulse), 0);
    check_output("por_busy", int'(bus.o_busy), 0);
    check_output("por_overflow", int'(bus.o_overflow), 0);
    rst_n = 1'b1;
    last_trig = 1'b1;
    apply_pattern(16'h03FF, 10);
    apply_pattern(16'h0000, 2);
    drain_check("reset_hold");

    $display("[TB] single trigger");
    apply_pattern(16'b0000_0000_0000_0001, 2);
    drain_check("single");

    $display("[TB] two queued triggers during HIGH");
    apply_pattern(16'b0000_0000_0001_0101, 6);
    drain_check("queued");

    $display("[TB] queue overflow");
    apply_pattern(16'b0000_0000_0101_0101, 8);
    drain_check("overflow");

    $display("[TB] restart on final gap cycle, empty queue");
    apply_pattern(16'b0000_0000_1000_0001, 9);
    drain_check("boundary_p0");

    $display("[TB] restart on final gap cycle, one queued");
    apply_pattern(16'b0000_0000_1000_0101, 9);
    drain_check("boundary_p1");

    $display("[TB] reset during HIGH with one queued");
    apply_pattern(16'b0000_0000_0000_0101, 3);
    do_reset(1'b0);
    apply_pattern(16'h0000, 15);
    drain_check("reset_mid");

    $display("[TB] random triggers");
    for (int i = 0; i < 400; i++) begin
      int rate;
      rate = (i < 200) ? 20 : 55;
      apply_stimulus(logic'($urandom_range(0, 99) < rate));
    end
    drain_check("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
